// File: rtl/chc2442_spi_master.sv
// chc2442_spi_master
// Drains the CHC2442 command FIFO and serialises each valid word onto the PLL SPI pins.
// Each FIFO word is {valid, is_read, frame[23:0]}. A word with valid=0 is popped and
// discarded. Any other word is shifted MSB-first in one CSN frame (CPOL=0, CPHA=0).
// On a read frame, the trailing RD_BITS MISO bits are returned on rd_data.
//
// FIFO handshake: fifo_rd_en is a one-cycle pop strobe. It is only raised from IDLE
// while fifo_empty=0. fifo_dout is treated as valid exactly one cycle later (the WAIT
// state) and is ignored at every other time.
//
// CSN-low frame length is CS_SETUP + FRAME_BITS*2*CLK_DIV + CS_HOLD + 2 cycles
// (198 with the default parameters). The extra two cycles come from:
//   - one CSN-assert cycle ahead of the setup count, and
//   - one settle cycle with SCLK low after the last falling edge, ahead of the hold count.
// The design uses the following timing:
//   SETUP lasts CS_SETUP+1 cycles.
//   Each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
//   HOLD lasts CS_HOLD+1 cycles.
//   GAP lasts CS_GAP cycles.
// The CSN-high time between frames is therefore CS_GAP+3 cycles (GAP + IDLE + POP + WAIT).
module chc2442_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_GAP     = 4,
    parameter int FRAME_BITS = 24,
    parameter int RD_BITS    = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               fifo_empty,
    input  logic [25:0]        fifo_dout,
    output logic               fifo_rd_en,
    output logic               spi_csn,
    output logic               spi_sclk,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic [RD_BITS-1:0] rd_data,
    output logic               rd_valid,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_WAIT  = 3'd2,
        S_SETUP = 3'd3,
        S_SHIFT = 3'd4,
        S_HOLD  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP);
    localparam logic [15:0] LOW_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HIGH_LAST  = 16'(2 * CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);
    localparam logic [7:0]  BIT_LAST   = 8'(FRAME_BITS - 1);

    state_t                state;
    logic [15:0]           cnt;
    logic [7:0]            bit_cnt;
    logic [FRAME_BITS-1:0] tx_sreg;
    logic [RD_BITS-1:0]    rx_sreg;
    logic                  is_read;

    // Frame sequencer: every output is a register updated on the transition that enters
    // the state in which that output takes effect.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            tx_sreg    <= '0;
            rx_sreg    <= '0;
            is_read    <= 1'b0;
            fifo_rd_en <= 1'b0;
            spi_csn    <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            rd_valid   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_POP;
                    end
                end
                S_POP: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // The popped word is on fifo_dout only during this cycle.
                    tx_sreg <= fifo_dout[FRAME_BITS-1:0];
                    is_read <= fifo_dout[24];
                    cnt     <= '0;
                    if (fifo_dout[25]) begin
                        spi_csn  <= 1'b0;
                        spi_mosi <= fifo_dout[FRAME_BITS-1];
                        state    <= S_SETUP;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == LOW_LAST) begin
                        // MISO is captured on the same edge that raises SCLK.
                        spi_sclk <= 1'b1;
                        rx_sreg  <= {rx_sreg[RD_BITS-2:0], spi_miso};
                        cnt      <= cnt + 16'd1;
                    end else if (cnt == HIGH_LAST) begin
                        spi_sclk <= 1'b0;
                        cnt      <= '0;
                        tx_sreg  <= tx_sreg << 1;
                        if (bit_cnt == BIT_LAST) begin
                            spi_mosi <= 1'b0;
                            state    <= S_HOLD;
                        end else begin
                            spi_mosi <= tx_sreg[FRAME_BITS-2];
                            bit_cnt  <= bit_cnt + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        spi_csn <= 1'b1;
                        cnt     <= '0;
                        state   <= S_GAP;
                        if (is_read) begin
                            rd_data  <= rx_sreg;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    spi_csn  <= 1'b1;
                    spi_sclk <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chc2442_spi_master.sv
// tb_chc2442_spi_master
// Directed bench for the CHC2442 SPI master.
// The bench provides:
//   - a FIFO model with 1-cycle read latency,
//   - a MISO slave model,
//   - a negedge bus monitor that records each CSN frame,
//   - a vector table of words with hand-computed frame and readback results.
module tb_chc2442_spi_master;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [25:0] fifo_dout = '0;
    logic        fifo_rd_en;
    logic        spi_csn;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;

    chc2442_spi_master dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .spi_csn    (spi_csn),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy)
    );

    // Clock and watchdog.
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    // FIFO model.
    // Words are written by the stimulus process and popped here.
    // fifo_dout carries junk except in the cycle after a pop.
    logic [25:0] word_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_count = 0;

    always @(posedge sys_clk) begin
        if (fifo_rd_en) begin
            if (rd_ptr != wr_ptr) begin
                fifo_dout <= word_mem[rd_ptr];
                rd_ptr = rd_ptr + 1;
            end
            pop_count = pop_count + 1;
        end else begin
            fifo_dout <= 26'($urandom());
        end
        fifo_empty <= (rd_ptr == wr_ptr);
    end

    // Bus monitor and MISO slave model.
    // MISO presents bit 23 when CSN falls, then moves to the next bit after each observed rise.
    logic [23:0] miso_word = '0;
    logic        prev_csn = 1'b1;
    logic        prev_sclk = 1'b0;
    int          cur_low = 0;
    int          cur_rises = 0;
    logic [23:0] cur_mosi = '0;
    int          high_run = 0;
    int          frame_count = 0;
    int          f_low [0:31];
    int          f_rises [0:31];
    logic [23:0] f_mosi [0:31];
    logic        f_rdv [0:31];
    int          f_gap [0:31];
    int          rd_en_total = 0;
    int          busy_total = 0;
    int          rdv_total = 0;
    int          low_total = 0;
    int          sclk_hi_total = 0;
    int          stray_rises = 0;

    always @(negedge sys_clk) begin
        if (fifo_rd_en === 1'b1) rd_en_total = rd_en_total + 1;
        if (busy === 1'b1) busy_total = busy_total + 1;
        if (rd_valid === 1'b1) rdv_total = rdv_total + 1;
        if (spi_sclk === 1'b1) sclk_hi_total = sclk_hi_total + 1;
        if (spi_csn === 1'b0) begin
            if (prev_csn === 1'b1) begin
                cur_low = 0;
                cur_rises = 0;
                cur_mosi = '0;
                f_gap[frame_count] = high_run;
                spi_miso = miso_word[23];
            end
            cur_low = cur_low + 1;
            low_total = low_total + 1;
            if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
                cur_mosi = {cur_mosi[22:0], spi_mosi};
                cur_rises = cur_rises + 1;
                if (cur_rises < 24) spi_miso = miso_word[23 - cur_rises];
            end
            high_run = 0;
        end else begin
            if (prev_csn === 1'b0) begin
                f_low[frame_count] = cur_low;
                f_rises[frame_count] = cur_rises;
                f_mosi[frame_count] = cur_mosi;
                f_rdv[frame_count] = rd_valid;
                frame_count = frame_count + 1;
            end
            high_run = high_run + 1;
            if (spi_sclk === 1'b1 && prev_sclk === 1'b0) stray_rises = stray_rises + 1;
        end
        prev_csn = spi_csn;
        prev_sclk = spi_sclk;
    end

    // Scoreboard helpers.
    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int idx, input int act, input int min_val);
        checks = checks + 1;
        if (act < min_val) begin
            errors = errors + 1;
            $display("FAIL %s[%0d]: got %0d expected at least %0d", name, idx, act, min_val);
        end
    endtask

    // Driver tasks. All sampling and driving happens 1 ns after the falling edge.
    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic push_word(input logic [25:0] w);
        word_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_done(input string name, input int idx, input int target_pops);
        int n;
        n = 0;
        while (!(pop_count >= target_pops && busy === 1'b0) && n < 3000) begin
            tick();
            n = n + 1;
        end
        check(name, idx, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [25:0] word;
        logic [23:0] miso;
        logic        exp_frame;
        logic        exp_rdv;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        int fc0, p0, r0, s0, n;

        // Word {valid, is_read, frame}, MISO pattern, frame expected, rd_valid expected, rd_data after.
        vecs[0] = '{26'h2A51234, 24'h000000, 1'b1, 1'b0, 16'h0000};
        vecs[1] = '{26'h3830000, 24'h5ABEEF, 1'b1, 1'b1, 16'hBEEF};
        vecs[2] = '{26'h1FFFFFF, 24'h0F0F0F, 1'b0, 1'b0, 16'hBEEF};
        vecs[3] = '{26'h25A5A5A, 24'hFFFFFF, 1'b1, 1'b0, 16'hBEEF};
        vecs[4] = '{26'h3000001, 24'h123456, 1'b1, 1'b1, 16'h3456};
        vecs[5] = '{26'h0123456, 24'h000000, 1'b0, 1'b0, 16'h3456};
        vecs[6] = '{26'h3FFFFFF, 24'h000000, 1'b1, 1'b1, 16'h0000};

        // Reset: check the register values held in the reset state.
        sys_rst = 1'b1;
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();
        check("rst_csn", 0, 32'(spi_csn), 32'd1);
        check("rst_sclk", 0, 32'(spi_sclk), 32'd0);
        check("rst_mosi", 0, 32'(spi_mosi), 32'd0);
        check("rst_rd_en", 0, 32'(fifo_rd_en), 32'd0);
        check("rst_busy", 0, 32'(busy), 32'd0);
        check("rst_rd_valid", 0, 32'(rd_valid), 32'd0);
        check("rst_rd_data", 0, 32'(rd_data), 32'd0);

        // Empty FIFO for 100 cycles: the DUT must not pop, assert CSN, toggle SCLK or go busy.
        r0 = rd_en_total;
        s0 = low_total;
        n = sclk_hi_total;
        fc0 = busy_total;
        repeat (100) tick();
        check("idle_rd_en", 0, 32'(rd_en_total - r0), 32'd0);
        check("idle_csn_low", 0, 32'(low_total - s0), 32'd0);
        check("idle_sclk_hi", 0, 32'(sclk_hi_total - n), 32'd0);
        check("idle_busy", 0, 32'(busy_total - fc0), 32'd0);

        // Vector table: one word at a time.
        for (int i = 0; i < 7; i++) begin
            miso_word = vecs[i].miso;
            fc0 = frame_count;
            p0 = pop_count;
            r0 = rdv_total;
            s0 = stray_rises;
            push_word(vecs[i].word);
            wait_done("v_done", i, p0 + 1);
            repeat (2) tick();
            check("v_pops", i, 32'(pop_count - p0), 32'd1);
            check("v_frames", i, 32'(frame_count - fc0), 32'(vecs[i].exp_frame));
            check("v_stray_sclk", i, 32'(stray_rises - s0), 32'd0);
            check("v_rdv_count", i, 32'(rdv_total - r0), 32'(vecs[i].exp_rdv));
            check("v_rd_data", i, 32'(rd_data), 32'(vecs[i].exp_rd));
            if (vecs[i].exp_frame) begin
                check("v_csn_low", i, 32'(f_low[fc0]), 32'd198);
                check("v_rises", i, 32'(f_rises[fc0]), 32'd24);
                check("v_mosi", i, 32'(f_mosi[fc0]), 32'(vecs[i].word[23:0]));
                check("v_rdv_on_csn_rise", i, 32'(f_rdv[fc0]), 32'(vecs[i].exp_rdv));
            end
        end

        // Two queued words: two complete frames separated by a CSN-high gap of at least CS_GAP+3 cycles.
        miso_word = 24'h00C0DE;
        fc0 = frame_count;
        p0 = pop_count;
        r0 = rdv_total;
        push_word(26'h23C3C3C);
        push_word(26'h3F0F0F0);
        wait_done("b2b_done", 0, p0 + 2);
        repeat (2) tick();
        check("b2b_frames", 0, 32'(frame_count - fc0), 32'd2);
        check("b2b_mosi0", 0, 32'(f_mosi[fc0]), 32'h3C3C3C);
        check("b2b_mosi1", 0, 32'(f_mosi[fc0 + 1]), 32'hF0F0F0);
        check("b2b_low1", 0, 32'(f_low[fc0 + 1]), 32'd198);
        check_ge("b2b_gap", 0, f_gap[fc0 + 1], 7);
        check("b2b_rdv_count", 0, 32'(rdv_total - r0), 32'd1);
        check("b2b_rd_data", 0, 32'(rd_data), 32'h0000C0DE);

        // Reset during bit 10 of a read frame: the frame is dropped, and the next queued word is sent complete.
        miso_word = 24'hFFFFFF;
        fc0 = frame_count;
        p0 = pop_count;
        r0 = rdv_total;
        push_word(26'h3AAAAAA);
        push_word(26'h2C33C5A);
        n = 0;
        while (!(spi_csn === 1'b0 && cur_rises == 10) && n < 3000) begin
            tick();
            n = n + 1;
        end
        check("rst_mid_reach", 0, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
        sys_rst = 1'b1;
        tick();
        check("rst_mid_csn", 0, 32'(spi_csn), 32'd1);
        check("rst_mid_sclk", 0, 32'(spi_sclk), 32'd0);
        check("rst_mid_busy", 0, 32'(busy), 32'd0);
        check("rst_mid_rd_valid", 0, 32'(rd_valid), 32'd0);
        sys_rst = 1'b0;
        wait_done("rst_mid_done", 0, p0 + 2);
        repeat (2) tick();
        check("rst_mid_frames", 0, 32'(frame_count - fc0), 32'd2);
        check("rst_mid_low", 0, 32'(f_low[fc0 + 1]), 32'd198);
        check("rst_mid_rises", 0, 32'(f_rises[fc0 + 1]), 32'd24);
        check("rst_mid_mosi", 0, 32'(f_mosi[fc0 + 1]), 32'hC33C5A);
        check("rst_mid_rdv_count", 0, 32'(rdv_total - r0), 32'd0);
        check("rst_mid_rd_data", 0, 32'(rd_data), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
